mem_arbiter: RTL

Three-requester arbiter and sequencer for the multi-cycle CPU's unified instruction/data memory. It sits between the memory and its users: CPU instruction fetch, CPU load/store, and the debug/program loader. It serialises their requests with round-robin fairness, issues exactly one memory access per transaction and returns a registered response. It also rejects out-of-range and misaligned addresses without touching memory.

---
 rtl/mem_arbiter_pkg.sv | 41 ++++
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter_rr_pick3.sv | 40 ++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter.
// - state_t   : sequencer states (IDLE -> ACCESS -> RESP -> IDLE).
// - req_idx_t : requester index. Bit positions in every 3-bit request/grant/ack
//               vector use the same index: IF=0, DM=1, DBG=2.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_IF  = 2'd0,
    REQ_DM  = 2'd1,
    REQ_DBG = 2'd2
  } req_idx_t;

  localparam int NUM_REQ = 3;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    case (idx)
      REQ_IF:  oh = 3'b001;
      REQ_DM:  oh = 3'b010;
      REQ_DBG: oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  function automatic req_idx_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    req_idx_t idx;
    idx = REQ_IF;
    if (oh[1]) idx = REQ_DM;
    if (oh[2]) idx = REQ_DBG;
    return idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the memory.
// - slave  : arbiter view (requests and mem_rdata in; acks, response,
//            busy and memory strobes out).
// - master : environment view (requesters plus memory model).
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;

  logic        if_ack;
  logic        dm_ack;
  logic        dbg_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output if_ack, dm_ack, dbg_ack, rsp_rdata, rsp_err, busy,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  if_ack, dm_ack, dbg_ack, rsp_rdata, rsp_err, busy,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick3.sv
// Three-way round-robin picker (combinational).
// Ports:
//   req[2:0]  pending requests, bit index = req_idx_t
//   last_gnt  requester that won most recently
//   gnt[2:0]  one-hot winner, zero when nothing is pending
//   valid     at least one request pending
// Search starts at the requester after last_gnt, order IF -> DM -> DBG -> IF.
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  req_idx_t   last_gnt,
  output logic [2:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt = '0;
    case (last_gnt)
      REQ_IF: begin
        if      (req[REQ_DM])  gnt = 3'b010;
        else if (req[REQ_DBG]) gnt = 3'b100;
        else if (req[REQ_IF])  gnt = 3'b001;
      end
      REQ_DM: begin
        if      (req[REQ_DBG]) gnt = 3'b100;
        else if (req[REQ_IF])  gnt = 3'b001;
        else if (req[REQ_DM])  gnt = 3'b010;
      end
      default: begin
        if      (req[REQ_IF])  gnt = 3'b001;
        else if (req[REQ_DM])  gnt = 3'b010;
        else if (req[REQ_DBG]) gnt = 3'b100;
      end
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester arbiter/sequencer for the unified instruction/data memory.
// Serialises IF fetch, DM load/store and DBG loader requests with round-robin
// fairness; one memory access per transaction; registered one-cycle response.
// Out-of-range and misaligned addresses are rejected without a memory strobe.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   bus         mem_arbiter_if.slave: requests in, acks/rsp_rdata/rsp_err/busy
//               out, memory address/data/strobes out, mem_rdata in
// Sequence: IDLE (sample+latch) -> ACCESS (strobe) -> RESP (ack) -> IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RAM_SIZE_BIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  state_t      state_q, state_d;
  req_idx_t    last_gnt_q;
  req_idx_t    lat_who_q;
  logic        lat_we_q;
  logic [31:0] lat_addr_q;
  logic [31:0] lat_wdata_q;
  logic [2:0]  ack_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [2:0]  pick_gnt;
  logic        pick_vld;
  req_idx_t    win_idx;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        addr_err;
  logic        in_access;

  rr_pick3 u_pick (
    .req      ({bus.dbg_req, bus.dm_req, bus.if_req}),
    .last_gnt (last_gnt_q),
    .gnt      (pick_gnt),
    .valid    (pick_vld)
  );

  // Winner's request fields; fetch is always a read.
  always_comb begin
    win_idx   = onehot_to_idx(pick_gnt);
    win_we    = 1'b0;
    win_addr  = bus.if_addr;
    win_wdata = '0;
    if (pick_gnt[REQ_DM]) begin
      win_we    = bus.dm_we;
      win_addr  = bus.dm_addr;
      win_wdata = bus.dm_wdata;
    end else if (pick_gnt[REQ_DBG]) begin
      win_we    = bus.dbg_we;
      win_addr  = bus.dbg_addr;
      win_wdata = bus.dbg_wdata;
    end
  end

  assign addr_err = (lat_addr_q[1:0] != 2'b00) ||
                    (lat_addr_q[31:RAM_SIZE_BIT+2] != '0);

  // ---- FSM state register ----
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- Latch in IDLE, response capture at end of ACCESS ----
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q  <= REQ_DBG;
      lat_who_q   <= REQ_IF;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      ack_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            last_gnt_q  <= win_idx;
            lat_who_q   <= win_idx;
            lat_we_q    <= win_we;
            lat_addr_q  <= win_addr;
            lat_wdata_q <= win_wdata;
          end
        end
        ACCESS: begin
          ack_q       <= idx_to_onehot(lat_who_q);
          rsp_rdata_q <= (!lat_we_q && !addr_err) ? bus.mem_rdata : '0;
          rsp_err_q   <= addr_err;
        end
        default: begin
          ack_q       <= '0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are gated by reset so a reset landing in ACCESS blocks the
  // write that the external memory would otherwise commit on that edge.
  assign in_access     = (state_q == ACCESS) && !reset;
  assign bus.mem_read  = in_access && !lat_we_q && !addr_err;
  assign bus.mem_write = in_access &&  lat_we_q && !addr_err;
  assign bus.mem_addr  = lat_addr_q;
  assign bus.mem_wdata = lat_wdata_q;

  assign bus.if_ack    = ack_q[REQ_IF];
  assign bus.dm_ack    = ack_q[REQ_DM];
  assign bus.dbg_ack   = ack_q[REQ_DBG];
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
